// File: rtl/ysyx_22050019_axi_rd_arb_pkg.sv
// Shared encodings for the IFU/LSU read-channel arbiter.
// Optional round-robin tie-break: define YSYX_22050019_ARB_RR_EN.
package ysyx_22050019_axi_rd_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2
  } arb_state_e;

  localparam logic REQ_IFU = 1'b0;
  localparam logic REQ_LSU = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/ysyx_22050019_arb_pick.sv
// Combinational 2-way requester selector; the tie-break policy lives here.
// YSYX_22050019_ARB_RR_EN selects round-robin ties, otherwise the LSU wins ties.
module ysyx_22050019_arb_pick
  import ysyx_22050019_axi_rd_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic winner,
  output logic valid
);

  assign valid = req0 | req1;

`ifdef YSYX_22050019_ARB_RR_EN
  // On a tie, hand the grant to whoever was not served last.
  always_comb begin
    winner = REQ_IFU;
    if (req0 && req1) winner = ~last;
    else if (req1)    winner = REQ_LSU;
  end
`else
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    winner = REQ_IFU;
    if (req1) winner = REQ_LSU;
  end
`endif

endmodule

// File: rtl/ysyx_22050019_axi_rd_arb.sv
// Two-requester arbiter (IFU=0, LSU=1) sharing one AXI4-Lite read channel, one outstanding.
// YSYX_22050019_ARB_RR_EN enables round-robin tie-break (default: LSU priority).
module ysyx_22050019_axi_rd_arb
  import ysyx_22050019_axi_rd_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              s0_arvalid,
  input  logic [ADDR_W-1:0] s0_araddr,
  output logic              s0_arready,
  output logic              s0_rvalid,
  output logic [DATA_W-1:0] s0_rdata,
  output logic [1:0]        s0_rresp,
  input  logic              s0_rready,

  input  logic              s1_arvalid,
  input  logic [ADDR_W-1:0] s1_araddr,
  output logic              s1_arready,
  output logic              s1_rvalid,
  output logic [DATA_W-1:0] s1_rdata,
  output logic [1:0]        s1_rresp,
  input  logic              s1_rready,

  output logic              m_axi_arvalid,
  output logic [ADDR_W-1:0] m_axi_araddr,
  input  logic              m_axi_arready,
  input  logic              m_axi_rvalid,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  output logic              m_axi_rready
);

  arb_state_e        state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic pick_winner;
  logic pick_valid;

  ysyx_22050019_arb_pick u_pick (
    .req0   (s0_arvalid),
    .req1   (s1_arvalid),
    .last   (last_q),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  // rst_n is active-high and synchronous.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= REQ_IFU;
      last_q  <= REQ_IFU;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
    end
  end

  // Next state and channel routing; everything is held at zero while reset is asserted.
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    last_d        = last_q;
    addr_d        = addr_q;
    s0_arready    = 1'b0;
    s1_arready    = 1'b0;
    s0_rvalid     = 1'b0;
    s0_rdata      = '0;
    s0_rresp      = RESP_OKAY;
    s1_rvalid     = 1'b0;
    s1_rdata      = '0;
    s1_rresp      = RESP_OKAY;
    m_axi_arvalid = 1'b0;
    m_axi_araddr  = '0;
    m_axi_rready  = 1'b0;

    if (!rst_n) begin
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            s0_arready = (pick_winner == REQ_IFU);
            s1_arready = (pick_winner == REQ_LSU);
            gnt_d      = pick_winner;
            last_d     = pick_winner;
            addr_d     = (pick_winner == REQ_LSU) ? s1_araddr : s0_araddr;
            state_d    = ST_AR;
          end
        end
        ST_AR: begin
          m_axi_arvalid = 1'b1;
          m_axi_araddr  = addr_q;
          if (m_axi_arready) state_d = ST_R;
        end
        ST_R: begin
          if (gnt_q == REQ_LSU) begin
            s1_rvalid    = m_axi_rvalid;
            s1_rdata     = m_axi_rdata;
            s1_rresp     = m_axi_rresp;
            m_axi_rready = s1_rready;
          end else begin
            s0_rvalid    = m_axi_rvalid;
            s0_rdata     = m_axi_rdata;
            s0_rresp     = m_axi_rresp;
            m_axi_rready = s0_rready;
          end
          if (m_axi_rvalid && m_axi_rready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050019_axi_rd_arb.sv
// Directed self-checking bench for the IFU/LSU read arbiter (both tie-break builds).
module tb_ysyx_22050019_axi_rd_arb;
  import ysyx_22050019_axi_rd_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s0_arvalid, s0_arready, s0_rvalid, s0_rready;
  logic [63:0] s0_araddr, s0_rdata;
  logic [1:0]  s0_rresp;
  logic        s1_arvalid, s1_arready, s1_rvalid, s1_rready;
  logic [63:0] s1_araddr, s1_rdata;
  logic [1:0]  s1_rresp;
  logic        m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
  logic [63:0] m_axi_araddr, m_axi_rdata;
  logic [1:0]  m_axi_rresp;

  int n_checks = 0;
  int n_fail   = 0;
  int n_rhs    = 0;

  always #5 clk = ~clk;

  ysyx_22050019_axi_rd_arb dut (
    .clk(clk), .rst_n(rst_n),
    .s0_arvalid(s0_arvalid), .s0_araddr(s0_araddr), .s0_arready(s0_arready),
    .s0_rvalid(s0_rvalid), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rready(s0_rready),
    .s1_arvalid(s1_arvalid), .s1_araddr(s1_araddr), .s1_arready(s1_arready),
    .s1_rvalid(s1_rvalid), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rready(s1_rready),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_araddr(m_axi_araddr), .m_axi_arready(m_axi_arready),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rready(m_axi_rready)
  );

  always @(posedge clk) if (m_axi_rvalid && m_axi_rready) n_rhs <= n_rhs + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_s0_arready"}, 64'(s0_arready), 64'd0);
    check({tag, "_s1_arready"}, 64'(s1_arready), 64'd0);
    check({tag, "_s0_rvalid"}, 64'(s0_rvalid), 64'd0);
    check({tag, "_s1_rvalid"}, 64'(s1_rvalid), 64'd0);
    check({tag, "_s0_rdata"}, s0_rdata, 64'd0);
    check({tag, "_m_arvalid"}, 64'(m_axi_arvalid), 64'd0);
    check({tag, "_m_araddr"}, m_axi_araddr, 64'd0);
    check({tag, "_m_rready"}, 64'(m_axi_rready), 64'd0);
  endtask

  // Called one step after the accepting edge: the DUT is in AR.
  task automatic slave_ar(input string tag, input logic [63:0] exp_addr);
    m_axi_arready = 1'b1;
    #1;
    check({tag, "_arvalid"}, 64'(m_axi_arvalid), 64'd1);
    check({tag, "_araddr"}, m_axi_araddr, exp_addr);
    check({tag, "_no_arready"}, 64'(s0_arready | s1_arready), 64'd0);
    next_cycle();
    m_axi_arready = 1'b0;
  endtask

  // Returns one beat to an always-ready requester and checks routing.
  task automatic slave_r(input string tag, input logic exp_gnt, input logic [63:0] data,
                         input logic [1:0] resp);
    m_axi_rvalid = 1'b1;
    m_axi_rdata  = data;
    m_axi_rresp  = resp;
    #1;
    check({tag, "_rvalid_gnt"}, 64'(exp_gnt ? s1_rvalid : s0_rvalid), 64'd1);
    check({tag, "_rdata_gnt"}, exp_gnt ? s1_rdata : s0_rdata, data);
    check({tag, "_rresp_gnt"}, 64'(exp_gnt ? s1_rresp : s0_rresp), 64'(resp));
    check({tag, "_rvalid_oth"}, 64'(exp_gnt ? s0_rvalid : s1_rvalid), 64'd0);
    check({tag, "_rdata_oth"}, exp_gnt ? s0_rdata : s1_rdata, 64'd0);
    check({tag, "_m_rready"}, 64'(m_axi_rready), 64'd1);
    next_cycle();
    m_axi_rvalid = 1'b0;
    m_axi_rdata  = '0;
    m_axi_rresp  = RESP_OKAY;
    #1;
    check({tag, "_idle"}, 64'(dut.state_q), 64'(ST_IDLE));
  endtask

  initial begin
    logic       exp_w;
    logic [1:0] rr_order;
    int         rhs0;

    rst_n = 1'b1;
    s0_arvalid = 1'b1; s0_araddr = 64'h8000_0000; s0_rready = 1'b1;
    s1_arvalid = 1'b0; s1_araddr = '0;            s1_rready = 1'b1;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = RESP_OKAY;

    // Reset: outputs stay low even with a pending request.
    next_cycle();
    next_cycle();
    check_quiet("rst");
    check("rst_state", 64'(dut.state_q), 64'(ST_IDLE));

    // IFU-only transaction with latency checks.
    rst_n = 1'b0;
    #1;
    check("t1_s0_arready", 64'(s0_arready), 64'd1);
    check("t1_s1_arready", 64'(s1_arready), 64'd0);
    check("t1_m_arvalid_T", 64'(m_axi_arvalid), 64'd0);
    next_cycle();
    s0_arvalid = 1'b0;
    slave_ar("t1_ar", 64'h8000_0000);
    slave_r("t1_r", REQ_IFU, 64'h0000_0013_0000_0093, RESP_OKAY);

    // Simultaneous requests: LSU first in both builds (last = IFU here).
    s0_arvalid = 1'b1; s0_araddr = 64'h8000_0004;
    s1_arvalid = 1'b1; s1_araddr = 64'h8000_1000;
    #1;
    check("t2_s1_arready", 64'(s1_arready), 64'd1);
    check("t2_s0_arready", 64'(s0_arready), 64'd0);
    next_cycle();
    s1_arvalid = 1'b0;
    slave_ar("t2_ar_lsu", 64'h8000_1000);
    slave_r("t2_r_lsu", REQ_LSU, 64'h1111_2222_3333_4444, RESP_OKAY);
    check("t2_s0_arready2", 64'(s0_arready), 64'd1);
    next_cycle();
    s0_arvalid = 1'b0;
    slave_ar("t2_ar_ifu", 64'h8000_0004);
    slave_r("t2_r_ifu", REQ_IFU, 64'h5555_6666_7777_8888, RESP_OKAY);

    // Continuous contention for 4 transactions.
    s0_arvalid = 1'b1; s0_araddr = 64'h8000_0100;
    s1_arvalid = 1'b1; s1_araddr = 64'h8000_2100;
    for (int i = 0; i < 4; i++) begin
`ifdef YSYX_22050019_ARB_RR_EN
      rr_order = 2'b01;
      exp_w = (i % 2 == 0) ? REQ_LSU : REQ_IFU;
`else
      rr_order = 2'b00;
      exp_w = REQ_LSU;
`endif
      #1;
      check($sformatf("t3_arready_%0d", i), 64'({s1_arready, s0_arready}),
            exp_w ? 64'd2 : 64'd1);
      next_cycle();
      slave_ar($sformatf("t3_ar_%0d", i), exp_w ? 64'h8000_2100 : 64'h8000_0100);
      slave_r($sformatf("t3_r_%0d", i), exp_w, 64'(i) + 64'hA0, RESP_OKAY);
    end
    s0_arvalid = 1'b0; s1_arvalid = 1'b0;
    if (rr_order != 2'b00) #1;

    // Slave AR stall then requester rready stall.
    s0_arvalid = 1'b1; s0_araddr = 64'h8000_2000;
    next_cycle();
    s0_arvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("t4_ar_hold_addr_%0d", i), m_axi_araddr, 64'h8000_2000);
      check($sformatf("t4_ar_hold_st_%0d", i), 64'(dut.state_q), 64'(ST_AR));
      next_cycle();
    end
    rhs0 = n_rhs;
    slave_ar("t4_ar", 64'h8000_2000);
    m_axi_rvalid = 1'b1; m_axi_rdata = 64'hDEAD_BEEF_0000_0001; s0_rready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check($sformatf("t4_r_hold_rvalid_%0d", i), 64'(s0_rvalid), 64'd1);
      check($sformatf("t4_r_hold_rready_%0d", i), 64'(m_axi_rready), 64'd0);
      check($sformatf("t4_r_hold_st_%0d", i), 64'(dut.state_q), 64'(ST_R));
      next_cycle();
    end
    s0_rready = 1'b1;
    slave_r("t4_r", REQ_IFU, 64'hDEAD_BEEF_0000_0001, RESP_OKAY);
    check("t4_one_rhs", 64'(n_rhs - rhs0), 64'd1);

    // Reset asserted while in R.
    s0_arvalid = 1'b1; s0_araddr = 64'h8000_3000;
    next_cycle();
    s0_arvalid = 1'b0;
    slave_ar("t5_ar", 64'h8000_3000);
    m_axi_rvalid = 1'b1; m_axi_rdata = 64'h1234; rst_n = 1'b1;
    #1;
    check_quiet("t5_during");
    next_cycle();
    m_axi_rvalid = 1'b0; m_axi_rdata = '0;
    check("t5_state", 64'(dut.state_q), 64'(ST_IDLE));
    check_quiet("t5_after");
    rst_n = 1'b0;
    s0_arvalid = 1'b1; s0_araddr = 64'h8000_0010;
    #1;
    check("t5_new_arready", 64'(s0_arready), 64'd1);
    next_cycle();
    s0_arvalid = 1'b0;
    slave_ar("t5_ar2", 64'h8000_0010);
    slave_r("t5_r2", REQ_IFU, 64'hCAFE_0000_0000_0010, RESP_OKAY);

    // SLVERR to LSU passes through; IFU follows unaffected.
    s1_arvalid = 1'b1; s1_araddr = 64'h8000_4000;
    next_cycle();
    s1_arvalid = 1'b0;
    slave_ar("t6_ar", 64'h8000_4000);
    slave_r("t6_r", REQ_LSU, 64'h0, RESP_SLVERR);
    s0_arvalid = 1'b1; s0_araddr = 64'h8000_0020;
    #1;
    check("t6_ifu_arready", 64'(s0_arready), 64'd1);
    next_cycle();
    s0_arvalid = 1'b0;
    slave_ar("t6_ar2", 64'h8000_0020);
    slave_r("t6_r2", REQ_IFU, 64'h0BAD_F00D, RESP_OKAY);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
